// File: rtl/cla_adder_pipelined.sv
// Two-level carry-lookahead adder/subtractor, 1-3 pipeline stages, valid/ready with a global stall.
// Define CLA_SATURATE_EN to add the sat input (signed clamp on overflow in the last stage).
module cla_adder_pipelined #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef CLA_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NG   = WIDTH / GROUP;
  localparam int LAST = STAGES - 1;

  if ((WIDTH % GROUP) != 0 || GROUP < 2 || GROUP > 8 || STAGES < 1 || STAGES > 3) begin : g_bad_params
    $error("cla_adder_pipelined: unsupported WIDTH/GROUP/STAGES combination");
  end

  // Per-group propagate (AND of p) and generate (OR-of-ANDs lookahead), packed as {gp, gg}.
  function automatic logic [2*NG-1:0] group_pg(input logic [WIDTH-1:0] p,
                                               input logic [WIDTH-1:0] g);
    logic [NG-1:0] gp;
    logic [NG-1:0] gg;
    logic          term;
    for (int j = 0; j < NG; j++) begin
      gp[j] = 1'b1;
      gg[j] = 1'b0;
      for (int k = 0; k < GROUP; k++) begin
        term = g[j*GROUP+k];
        for (int m = k + 1; m < GROUP; m++) term = term & p[j*GROUP+m];
        gg[j] = gg[j] | term;
        gp[j] = gp[j] & p[j*GROUP+k];
      end
    end
    return {gp, gg};
  endfunction

  // Second-level lookahead: carry into every group, each a flat sum of products of GP/GG/c0.
  function automatic logic [NG:0] group_carries(input logic [NG-1:0] gp,
                                                input logic [NG-1:0] gg,
                                                input logic          c0);
    logic [NG:0] gc;
    logic        term;
    gc[0] = c0;
    for (int j = 1; j <= NG; j++) begin
      gc[j] = c0;
      for (int m = 0; m < j; m++) gc[j] = gc[j] & gp[m];
      for (int k = 0; k < j; k++) begin
        term = gg[k];
        for (int m = k + 1; m < j; m++) term = term & gp[m];
        gc[j] = gc[j] | term;
      end
    end
    return gc;
  endfunction

  // First-level lookahead inside each group from that group's carry-in.
  function automatic logic [WIDTH:0] bit_carries(input logic [WIDTH-1:0] p,
                                                 input logic [WIDTH-1:0] g,
                                                 input logic [NG:0]      gc);
    logic [WIDTH:0] c;
    logic           cc;
    logic           term;
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < GROUP; i++) begin
        cc = gc[j];
        for (int m = 0; m < i; m++) cc = cc & p[j*GROUP+m];
        for (int k = 0; k < i; k++) begin
          term = g[j*GROUP+k];
          for (int m = k + 1; m < i; m++) term = term & p[j*GROUP+m];
          cc = cc | term;
        end
        c[j*GROUP+i] = cc;
      end
    end
    c[WIDTH] = gc[NG];
    return c;
  endfunction

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] g0;
  logic [NG-1:0]    gp0;
  logic [NG-1:0]    gg0;
  logic             c0_0;
  logic             sat0;

  assign b_eff      = sub ? ~b : b;
  assign p0         = a ^ b_eff;
  assign g0         = a & b_eff;
  assign c0_0       = sub ? 1'b1 : cin;
  assign {gp0, gg0} = group_pg(p0, g0);

`ifdef CLA_SATURATE_EN
  assign sat0 = sat;
`else
  assign sat0 = 1'b0;
`endif

  logic [STAGES-1:0] v;
  logic              adv;
  logic              feed_valid;
  logic [WIDTH-1:0]  pf;
  logic [WIDTH-1:0]  gf;
  logic [NG:0]       gcf;
  logic              amf;
  logic              satf;

  assign out_valid = v[LAST];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  if (STAGES == 1) begin : g_one
    assign pf         = p0;
    assign gf         = g0;
    assign gcf        = group_carries(gp0, gg0, c0_0);
    assign amf        = a[WIDTH-1];
    assign satf       = sat0;
    assign feed_valid = in_valid;
  end else begin : g_multi
    logic [WIDTH-1:0] p1;
    logic [WIDTH-1:0] g1;
    logic [NG-1:0]    gp1;
    logic [NG-1:0]    gg1;
    logic             c0_1;
    logic             am1;
    logic             sat1;

    always_ff @(posedge clk) begin
      if (adv) begin
        p1   <= p0;
        g1   <= g0;
        gp1  <= gp0;
        gg1  <= gg0;
        c0_1 <= c0_0;
        am1  <= a[WIDTH-1];
        sat1 <= sat0;
      end
    end

    if (STAGES == 2) begin : g_two
      assign pf         = p1;
      assign gf         = g1;
      assign gcf        = group_carries(gp1, gg1, c0_1);
      assign amf        = am1;
      assign satf       = sat1;
      assign feed_valid = v[0];
    end else begin : g_three
      logic [WIDTH-1:0] p2;
      logic [WIDTH-1:0] g2;
      logic [NG:0]      gc2;
      logic             am2;
      logic             sat2;

      always_ff @(posedge clk) begin
        if (adv) begin
          p2   <= p1;
          g2   <= g1;
          gc2  <= group_carries(gp1, gg1, c0_1);
          am2  <= am1;
          sat2 <= sat1;
        end
      end

      assign pf         = p2;
      assign gf         = g2;
      assign gcf        = gc2;
      assign amf        = am2;
      assign satf       = sat2;
      assign feed_valid = v[1];
    end
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] sum_n;
  logic             cout_w;
  logic             ovf_w;
  logic             unused_g_top;

  assign c      = bit_carries(pf, gf, gcf);
  assign sum_w  = pf ^ c[WIDTH-1:0];
  assign cout_w = c[WIDTH];
  assign ovf_w  = c[WIDTH] ^ c[WIDTH-1];
  // The top generate bit of each group only matters through GG, so it is dead past stage 1.
  assign unused_g_top = ^gf;

  always_comb begin
    sum_n = sum_w;
    if (satf && ovf_w) begin
      sum_n = amf ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v      <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      v[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) v[k] <= v[k-1];
      if (feed_valid) begin
        sum_q  <= sum_n;
        cout_q <= cout_w;
        ovf_q  <= ovf_w;
        zero_q <= ~|sum_n;
      end
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule
